bcd_scan_decoder: RTL and testbench

BCD_SCAN_DECODER -- requirements
Module: bcd_scan_decoder

---
 rtl/bcd_scan_decoder.sv | 136 +++++++++++++
 tb/tb_bcd_scan_decoder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_decoder.sv
// Multiplexed BCD display scanner: holds DIGITS packed BCD digits, steps through them every SCAN_DIV clocks
// and drives a registered one-hot decimal decode. Define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module bcd_scan_decoder #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [9:0]            dec_out,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  invalid,
    output logic                  frame_done
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

    logic [4*DIGITS-1:0] data_q, data_d;
    logic [PRE_W-1:0]    presc_q, presc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                wrap_q, wrap_d;
    logic [9:0]          dec_out_q, dec_out_d;
    logic [DIGITS-1:0]   digit_sel_q, digit_sel_d;
    logic                invalid_q, invalid_d;
    logic                frame_done_q, frame_done_d;

    logic                adv_s;
    logic [3:0]          sel_nib_s;
    logic [DIGITS-1:0]   blank_s;
    logic                sel_blank_s;
`ifdef LEADING_ZERO_BLANK_EN
    logic                zero_run_s;
`endif

    function automatic logic [9:0] bcd_to_onehot(input logic [3:0] nib);
        logic [9:0] onehot;
        if (nib <= 4'd9) begin
            onehot = 10'b00_0000_0001 << nib;
        end else begin
            onehot = 10'b00_0000_0000;
        end
        return onehot;
    endfunction

    function automatic logic nib_is_bad(input logic [3:0] nib);
        return (nib > 4'd9);
    endfunction

    // Scan timing: prescaler, digit index and the end-of-frame marker.
    always_comb begin
        adv_s   = (presc_q == PRE_LAST);
        presc_d = presc_q;
        idx_d   = idx_q;
        if (adv_s) begin
            presc_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            presc_d = presc_q + PRE_W'(1);
        end
        wrap_d       = adv_s && (idx_q == IDX_LAST);
        frame_done_d = wrap_q;
        if (load) begin
            data_d = bcd_in;
        end else begin
            data_d = data_q;
        end
    end

    // Leading-zero mask: a digit above 0 is blank when it and every digit above it are zero.
    always_comb begin
        blank_s = '0;
`ifdef LEADING_ZERO_BLANK_EN
        zero_run_s = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run_s = zero_run_s & (data_q[4*k +: 4] == 4'd0);
            blank_s[k] = zero_run_s;
        end
`endif
    end

    // Output decode from the current held data and scan position.
    always_comb begin
        sel_nib_s   = 4'd0;
        sel_blank_s = 1'b0;
        invalid_d   = 1'b0;
        digit_sel_d = '0;
        for (int k = 0; k < DIGITS; k++) begin
            digit_sel_d[k] = (idx_q == IDX_W'(k));
            sel_nib_s      = sel_nib_s | (data_q[4*k +: 4] & {4{digit_sel_d[k]}});
            sel_blank_s    = sel_blank_s | (blank_s[k] & digit_sel_d[k]);
            invalid_d      = invalid_d | nib_is_bad(data_q[4*k +: 4]);
        end
        if (sel_blank_s) begin
            dec_out_d = 10'b00_0000_0000;
        end else begin
            dec_out_d = bcd_to_onehot(sel_nib_s);
        end
    end

    // State and output registers; reset wins over load and aborts any pending frame pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q       <= '0;
            presc_q      <= '0;
            idx_q        <= '0;
            wrap_q       <= 1'b0;
            dec_out_q    <= 10'b00_0000_0000;
            digit_sel_q  <= '0;
            invalid_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            data_q       <= data_d;
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            wrap_q       <= wrap_d;
            dec_out_q    <= dec_out_d;
            digit_sel_q  <= digit_sel_d;
            invalid_q    <= invalid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign dec_out    = dec_out_q;
    assign digit_sel  = digit_sel_q;
    assign invalid    = invalid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_scan_decoder.sv
// Directed self-checking bench for bcd_scan_decoder with DIGITS=4, SCAN_DIV=4.
module tb_bcd_scan_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] bcd_in = 16'h0000;
    logic [9:0]  dec_out;
    logic [3:0]  digit_sel;
    logic        invalid;
    logic        frame_done;

    int errors = 0;
    int checks = 0;
    int n = 0;   // edges since reset release

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    bcd_scan_decoder #(.DIGITS(4), .SCAN_DIV(4)) dut (
        .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in),
        .dec_out(dec_out), .digit_sel(digit_sel), .invalid(invalid), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task step;
        @(posedge clk);
        #1;
        n++;
    endtask

    task load_val(input logic [15:0] v);
        bcd_in = v;
        load   = 1'b1;
        step;
        load   = 1'b0;
    endtask

    // Outputs after edge n show slot ((n-1)/4)%4; frame_done pulses at n = 17, 33, ...
    task automatic check_frame(input string name, input logic [9:0] e0, input logic [9:0] e1,
                               input logic [9:0] e2, input logic [9:0] e3, input logic einv);
        logic [9:0] exp_dec;
        logic [3:0] exp_sel;
        logic       exp_fd;
        int         k;
        for (int i = 0; i < 16; i++) begin
            step;
            k = ((n - 1) / 4) % 4;
            case (k)
                0: exp_dec = e0;
                1: exp_dec = e1;
                2: exp_dec = e2;
                default: exp_dec = e3;
            endcase
            exp_sel = 4'b0001 << k;
            exp_fd  = (n > 1) && (((n - 1) % 16) == 0);
            checks++;
            if (dec_out !== exp_dec) begin
                errors++;
                $display("FAIL %s dec_out n=%0d: got %b expected %b", name, n, dec_out, exp_dec);
            end
            checks++;
            if (digit_sel !== exp_sel) begin
                errors++;
                $display("FAIL %s digit_sel n=%0d: got %b expected %b", name, n, digit_sel, exp_sel);
            end
            checks++;
            if (invalid !== einv) begin
                errors++;
                $display("FAIL %s invalid n=%0d: got %b expected %b", name, n, invalid, einv);
            end
            checks++;
            if (frame_done !== exp_fd) begin
                errors++;
                $display("FAIL %s frame_done n=%0d: got %b expected %b", name, n, frame_done, exp_fd);
            end
        end
    endtask

    task test_reset;
        rst    = 1'b1;
        load   = 1'b1;
        bcd_in = 16'h1234;
        step;
        step;
        checks++;
        if (dec_out !== 10'h000 || digit_sel !== 4'b0000 || invalid !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got dec=%b sel=%b inv=%b fd=%b expected all zero",
                     dec_out, digit_sel, invalid, frame_done);
        end
        rst  = 1'b0;
        load = 1'b0;
        n    = 0;
        step;
        checks++;
        if (digit_sel !== 4'b0001 || dec_out !== 10'h001) begin
            errors++;
            $display("FAIL reset_release: got sel=%b dec=%b expected sel=0001 dec=0000000001",
                     digit_sel, dec_out);
        end
    endtask

    task test_scan_sequence;
        check_frame("scan_zero_a", 10'h001, 10'h001, 10'h001, 10'h001, 1'b0);
        check_frame("scan_zero_b", 10'h001, 10'h001, 10'h001, 10'h001, 1'b0);
    endtask

    task test_digits;
        load_val(16'h1937);
        check_frame("digits_1937", 10'h080, 10'h008, 10'h200, 10'h002, 1'b0);
    endtask

    task test_invalid;
        bcd_in = 16'h0A05;
        load   = 1'b1;
        step;
        load   = 1'b0;
        checks++;
        if (invalid !== 1'b0) begin
            errors++;
            $display("FAIL invalid_latency: got %b expected 0 on load edge", invalid);
        end
        step;
        checks++;
        if (invalid !== 1'b1) begin
            errors++;
            $display("FAIL invalid_rise: got %b expected 1", invalid);
        end
        check_frame("invalid_0a05", 10'h020, 10'h001, 10'h000, BLANK ? 10'h000 : 10'h001, 1'b1);
        load_val(16'h0005);
        check_frame("valid_0005", 10'h020, BLANK ? 10'h000 : 10'h001,
                    BLANK ? 10'h000 : 10'h001, BLANK ? 10'h000 : 10'h001, 1'b0);
    endtask

    task test_blank;
        load_val(16'h0042);
        check_frame("blank_0042", 10'h004, 10'h010, BLANK ? 10'h000 : 10'h001,
                    BLANK ? 10'h000 : 10'h001, 1'b0);
    endtask

    task test_back_to_back;
        for (int i = 0; i < 16 && (n % 16) != 3; i++) step;
        bcd_in = 16'h8888;
        load   = 1'b1;
        step;
        load   = 1'b0;
        checks++;
        if (digit_sel !== 4'b0001 || dec_out !== 10'h004) begin
            errors++;
            $display("FAIL adv_load_edge: got sel=%b dec=%b expected sel=0001 dec=%b",
                     digit_sel, dec_out, 10'h004);
        end
        for (int i = 0; i < 4; i++) begin
            step;
            checks++;
            if (digit_sel !== 4'b0010 || dec_out !== 10'h100) begin
                errors++;
                $display("FAIL adv_load_digit1 n=%0d: got sel=%b dec=%b expected sel=0010 dec=%b",
                         n, digit_sel, dec_out, 10'h100);
            end
        end
        step;
        checks++;
        if (digit_sel !== 4'b0100 || dec_out !== 10'h100) begin
            errors++;
            $display("FAIL adv_load_prescaler: got sel=%b dec=%b expected sel=0100 dec=%b",
                     digit_sel, dec_out, 10'h100);
        end
    endtask

    task test_reset_mid_frame;
        for (int i = 0; i < 16 && (n % 16) != 6; i++) step;
        rst    = 1'b1;
        load   = 1'b1;
        bcd_in = 16'h9999;
        step;
        checks++;
        if (dec_out !== 10'h000 || digit_sel !== 4'b0000 || invalid !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got dec=%b sel=%b inv=%b fd=%b expected all zero",
                     dec_out, digit_sel, invalid, frame_done);
        end
        rst  = 1'b0;
        load = 1'b0;
        n    = 0;
        step;
        checks++;
        if (digit_sel !== 4'b0001 || dec_out !== 10'h001 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_restart: got sel=%b dec=%b fd=%b expected sel=0001 dec=0000000001 fd=0",
                     digit_sel, dec_out, frame_done);
        end
        check_frame("midreset_frame", 10'h001, 10'h001, 10'h001, 10'h001, 1'b0);
    endtask

    initial begin
        test_reset;
        test_scan_sequence;
        test_digits;
        test_invalid;
        test_blank;
        test_back_to_back;
        test_reset_mid_frame;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
